// File: rtl/goomba_scheduler_if.sv
// Tile read bus between the goomba scheduler (master) and the background
// tile memory (slave). The request, row and column stay held until ack.
// tile_data is valid in the cycle that tile_ack is high.
interface goomba_scheduler_if;
    logic       tile_req;
    logic [3:0] tile_row;
    logic [4:0] tile_col;
    logic       tile_ack;
    logic [7:0] tile_data;

    modport master (output tile_req, tile_row, tile_col, input tile_ack, tile_data);
    modport slave  (input tile_req, tile_row, tile_col, output tile_ack, tile_data);
endinterface

// File: rtl/goomba_scheduler.sv
// goomba_scheduler: time-multiplexed mover for up to NUM_SLOTS goombas.
// Each move_tick starts one pass. The pass first handles a spawn attempt.
// It then visits every slot in turn, reading the tile ahead through one shared
// tile port, moving or reversing the goomba, and testing it against Mario.
// Optional feature macro GOOMBA_STOMP_EN: when it is defined, landing on a
// goomba's top half removes that goomba instead of setting lose.
module goomba_scheduler #(
    parameter int NUM_SLOTS       = 4,
    parameter int BDR             = 0,
    parameter int SKY             = 1,
    parameter int BLK             = 2,
    parameter int GND             = 3,
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int BLOCK_WIDTH     = 40,
    parameter int GOOMBA_Y        = 360,
    parameter int SPAWN_X         = 600,
    parameter int SPAWN_PERIOD    = 256,
    parameter int STEP            = 1
) (
    input  logic                      vga_clock,
    input  logic                      reset,
    input  logic                      move_tick,
    input  logic signed [31:0]        mario_x,
    input  logic signed [31:0]        mario_y,
    goomba_scheduler_if.master        tile_bus,
    output logic [NUM_SLOTS*32-1:0]   goomba_x,
    output logic [31:0]               goomba_y,
    output logic [NUM_SLOTS-1:0]      goomba_active,
    output logic                      busy,
    output logic                      lose
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_MOVE  = 3'd5;
    localparam logic [2:0] S_HIT   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

    logic [2:0]                 state_reg;
    logic [2:0]                 slot_reg;
    logic [31:0]                spawn_cnt_reg;
    logic signed [31:0]         probe_reg;
    logic [7:0]                 tile_reg;
    logic                       tile_req_reg;
    logic [3:0]                 tile_row_reg;
    logic [4:0]                 tile_col_reg;
    logic                       busy_reg;
    logic                       lose_reg;

    logic [NUM_SLOTS*32-1:0]    x_flat;
    logic [NUM_SLOTS-1:0]       dir_vec;   // 1 = moving right
    logic [NUM_SLOTS-1:0]       act_vec;

    logic signed [31:0]         cur_x;
    logic                       cur_dir;
    logic                       cur_active;
    logic                       free_found;
    logic [2:0]                 free_idx;
    logic signed [31:0]         probe_x;
    logic                       probe_oob;
    logic                       tile_solid;
    logic signed [31:0]         moved_x;
    logic                       kill;
    logic signed [32:0]         dx;
    logic signed [32:0]         dy;
    logic signed [32:0]         adx;
    logic signed [32:0]         ady;
    logic                       overlap;
    logic                       stomp;
    logic                       spawn_wrap;
    logic                       spawn_hit;

    // Select the slot currently being visited and find the lowest free slot.
    always_comb begin
        cur_x      = '0;
        cur_dir    = 1'b0;
        cur_active = 1'b0;
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_reg == 3'(k)) begin
                cur_x      = x_flat[k*32 +: 32];
                cur_dir    = dir_vec[k];
                cur_active = act_vec[k];
            end
        end
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!act_vec[k]) begin
                free_found = 1'b1;
                free_idx   = 3'(k);
            end
        end
    end

    // Decode the captured tile: border and block stop a goomba, anything else is open.
    always_comb begin
        case (tile_reg)
            8'(BLK), 8'(BDR): tile_solid = 1'b1;
            8'(SKY), 8'(GND): tile_solid = 1'b0;
            default:          tile_solid = 1'b0;
        endcase
    end

    // Probe point, move result and Mario overlap for the current slot (33-bit distances).
    always_comb begin
        probe_x   = cur_dir ? cur_x + CHARACTER_WIDTH - 1 + STEP : cur_x - STEP;
        probe_oob = (probe_x < 0) || (probe_x >= SCREEN_WIDTH);
        moved_x   = tile_solid ? cur_x : (cur_dir ? cur_x + STEP : cur_x - STEP);
        kill      = (moved_x + CHARACTER_WIDTH) <= 0;
        dx        = 33'(mario_x) - 33'(cur_x);
        dy        = 33'(mario_y) - 33'(GOOMBA_Y);
        adx       = dx[32] ? -dx : dx;
        ady       = dy[32] ? -dy : dy;
        overlap   = (adx < 33'(CHARACTER_WIDTH)) && (ady < 33'(CHARACTER_WIDTH));
    end

`ifdef GOOMBA_STOMP_EN
    assign stomp = overlap && (mario_y + CHARACTER_WIDTH - 1 < GOOMBA_Y + CHARACTER_WIDTH / 2);
`else
    assign stomp = 1'b0;
`endif

    assign spawn_wrap = (spawn_cnt_reg == 32'(SPAWN_PERIOD - 1));
    assign spawn_hit  = (state_reg == S_SPAWN) && spawn_wrap && free_found;

    // Per-slot state: position, heading and alive flag.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        logic signed [31:0] x_reg;
        logic               dir_reg;
        logic               act_reg;

        // Update this slot on spawn, on its own move step, or on a stomp.
        always_ff @(posedge vga_clock or negedge reset) begin
            if (!reset) begin
                x_reg   <= '0;
                dir_reg <= 1'b0;
                act_reg <= 1'b0;
            end else if (spawn_hit && free_idx == 3'(gi)) begin
                x_reg   <= 32'(SPAWN_X);
                dir_reg <= 1'b0;
                act_reg <= 1'b1;
            end else if (state_reg == S_MOVE && slot_reg == 3'(gi)) begin
                x_reg <= moved_x;
                if (tile_solid) dir_reg <= ~dir_reg;
                if (kill) act_reg <= 1'b0;
            end else if (state_reg == S_HIT && slot_reg == 3'(gi) && act_reg && stomp) begin
                act_reg <= 1'b0;
            end
        end

        assign x_flat[gi*32 +: 32] = x_reg;
        assign dir_vec[gi]         = dir_reg;
        assign act_vec[gi]         = act_reg;
    end

    // Pass sequencer: spawn, then visit every slot through the shared tile port.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            slot_reg      <= 3'd0;
            spawn_cnt_reg <= '0;
            probe_reg     <= '0;
            tile_reg      <= '0;
            tile_req_reg  <= 1'b0;
            tile_row_reg  <= '0;
            tile_col_reg  <= '0;
            busy_reg      <= 1'b0;
            lose_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (move_tick && !lose_reg) begin
                        busy_reg  <= 1'b1;
                        state_reg <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    spawn_cnt_reg <= spawn_wrap ? '0 : spawn_cnt_reg + 32'd1;
                    slot_reg      <= 3'd0;
                    state_reg     <= S_SCAN;
                end
                S_SCAN: begin
                    if (!cur_active) begin
                        if (slot_reg == LAST_SLOT) begin
                            state_reg <= S_DONE;
                        end else begin
                            slot_reg  <= slot_reg + 3'd1;
                            state_reg <= S_SCAN;
                        end
                    end else begin
                        probe_reg <= probe_x;
                        if (probe_oob) begin
                            tile_reg  <= 8'(BDR);
                            state_reg <= S_MOVE;
                        end else begin
                            state_reg <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    tile_req_reg <= 1'b1;
                    tile_row_reg <= 4'(GOOMBA_Y / BLOCK_WIDTH);
                    tile_col_reg <= 5'(probe_reg / BLOCK_WIDTH);
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile_bus.tile_ack) begin
                        tile_req_reg <= 1'b0;
                        tile_reg     <= tile_bus.tile_data;
                        state_reg    <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    state_reg <= S_HIT;
                end
                S_HIT: begin
                    if (cur_active && overlap && !stomp) lose_reg <= 1'b1;
                    if (slot_reg == LAST_SLOT) begin
                        state_reg <= S_DONE;
                    end else begin
                        slot_reg  <= slot_reg + 3'd1;
                        state_reg <= S_SCAN;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign tile_bus.tile_req = tile_req_reg;
    assign tile_bus.tile_row = tile_row_reg;
    assign tile_bus.tile_col = tile_col_reg;
    assign goomba_x          = x_flat;
    assign goomba_active     = act_vec;
    assign goomba_y          = 32'(GOOMBA_Y);
    assign busy              = busy_reg;
    assign lose              = lose_reg;
endmodule

// File: tb/tb_goomba_scheduler.sv
// Testbench for goomba_scheduler. A pass-level reference model applies the
// movement, spawn and hit rules to plain integer arrays. A randomized tile
// responder serves the tile bus and logs every request for comparison.
module tb_goomba_scheduler;
    localparam int NS  = 4;
    localparam int SP  = 4;
    localparam int CW  = 42;
    localparam int GY  = 360;
    localparam logic [7:0] T_BDR = 8'd0;
    localparam logic [7:0] T_SKY = 8'd1;
    localparam logic [7:0] T_BLK = 8'd2;
    localparam logic [7:0] T_GND = 8'd3;

    logic                  clk;
    logic                  reset;
    logic                  move_tick;
    logic signed [31:0]    mario_x;
    logic signed [31:0]    mario_y;
    logic [NS*32-1:0]      goomba_x;
    logic [31:0]           goomba_y;
    logic [NS-1:0]         goomba_active;
    logic                  busy;
    logic                  lose;

    goomba_scheduler_if bus ();

    goomba_scheduler #(.NUM_SLOTS(NS), .SPAWN_PERIOD(SP)) dut (
        .vga_clock     (clk),
        .reset         (reset),
        .move_tick     (move_tick),
        .mario_x       (mario_x),
        .mario_y       (mario_y),
        .tile_bus      (bus),
        .goomba_x      (goomba_x),
        .goomba_y      (goomba_y),
        .goomba_active (goomba_active),
        .busy          (busy),
        .lose          (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pass_num = 0;

    // Tile memory contents, indexed wide enough for any row/col the DUT might send.
    logic [7:0] tile_map [16][32];
    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    bit         hold_ack = 1'b0;
    int         spur_cnt = 0;
    int         spur_done = 0;

    // Reference model state.
    int m_x [NS];
    bit m_dir [NS];
    bit m_act [NS];
    int m_cnt;
    bit m_lose;
    int m_k;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tile responder: random ack delay, optional hold, and spurious acks while idle.
    initial begin
        bit pending;
        int delay;
        pending = 1'b0;
        delay = 0;
        bus.tile_ack = 1'b0;
        bus.tile_data = 8'd0;
        forever begin
            @(negedge clk);
            if (bus.tile_ack) begin
                bus.tile_ack = 1'b0;
            end else if (bus.tile_req) begin
                if (!pending) begin
                    pending = 1'b1;
                    obs_q.push_back({bus.tile_row, bus.tile_col});
                    delay = $urandom_range(0, 3);
                end
                if (!hold_ack) begin
                    if (delay == 0) begin
                        bus.tile_ack = 1'b1;
                        bus.tile_data = tile_map[bus.tile_row][bus.tile_col];
                        pending = 1'b0;
                    end else begin
                        delay--;
                    end
                end
            end else begin
                pending = 1'b0;
                if (spur_cnt != spur_done) begin
                    bus.tile_ack = 1'b1;
                    bus.tile_data = T_BLK;
                    spur_done++;
                end
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_x[s] = 0;
            m_dir[s] = 1'b0;
            m_act[s] = 1'b0;
        end
        m_cnt = 0;
        m_lose = 1'b0;
    endtask

    // One full pass computed from the rules, per goomba, in slot order.
    task automatic model_pass();
        int p;
        int col;
        logic [7:0] t;
        bit spawned;
        longint dxl, dyl;
        if (m_cnt == SP - 1) begin
            m_cnt = 0;
            spawned = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if (!spawned && !m_act[s]) begin
                    m_act[s] = 1'b1;
                    m_x[s] = 600;
                    m_dir[s] = 1'b0;
                    spawned = 1'b1;
                end
            end
        end else begin
            m_cnt++;
        end
        m_k = 0;
        for (int s = 0; s < NS; s++) begin
            if (m_act[s]) begin
                m_k++;
                p = m_dir[s] ? m_x[s] + CW : m_x[s] - 1;
                if (p < 0 || p >= 640) begin
                    t = T_BDR;
                end else begin
                    col = p / 40;
                    exp_q.push_back({4'd9, 5'(col)});
                    t = tile_map[9][col];
                end
                if (t == T_BLK || t == T_BDR) m_dir[s] = !m_dir[s];
                else m_x[s] = m_dir[s] ? m_x[s] + 1 : m_x[s] - 1;
                if (m_x[s] + CW <= 0) m_act[s] = 1'b0;
                dxl = longint'(mario_x) - longint'(m_x[s]);
                dyl = longint'(mario_y) - longint'(GY);
                if (dxl < 0) dxl = -dxl;
                if (dyl < 0) dyl = -dyl;
                if (m_act[s] && dxl < CW && dyl < CW) begin
`ifdef GOOMBA_STOMP_EN
                    if (longint'(mario_y) + CW - 1 < GY + CW / 2) m_act[s] = 1'b0;
                    else m_lose = 1'b1;
`else
                    m_lose = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic check_state(input string phase);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("%s_x%0d", phase, s), $signed(goomba_x[s*32 +: 32]), m_x[s]);
            chk($sformatf("%s_active%0d", phase, s), goomba_active[s], m_act[s]);
        end
        chk({phase, "_lose"}, lose, m_lose);
        chk({phase, "_busy"}, busy, 0);
        chk({phase, "_tile_req"}, bus.tile_req, 0);
    endtask

    task automatic do_pass();
        int cyc;
        bit started;
        if ($urandom_range(0, 3) == 0) begin
            spur_cnt++;
            repeat (3) @(negedge clk);
        end
        started = !m_lose;
        if (started) model_pass();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        if (!started) begin
            for (int c = 0; c < 6; c++) begin
                chk("after_lose_busy", busy, 0);
                @(negedge clk);
            end
            chk("after_lose_reqs", obs_q.size(), 0);
            $display("pass %0d: ignored (lose latched)", pass_num);
            pass_num++;
            return;
        end
        chk("busy_start", busy, 1);
        cyc = 1;
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("pass_timeout", busy, 0);
        chk("pass_latency_ok", (cyc <= 3 + NS + m_k * 8) ? 1 : 0, 1);
        chk("req_count", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) chk("req_rowcol", obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        check_state("pass");
        $display("pass %0d: active=%b x0=%0d lose=%0d cycles=%0d", pass_num, goomba_active,
                 $signed(goomba_x[31:0]), lose, cyc);
        pass_num++;
    endtask

    task automatic random_row9();
        int r;
        for (int c = 0; c < 32; c++) begin
            r = $urandom_range(0, 9);
            if (r < 2) tile_map[9][c] = T_BLK;
            else if (r == 2) tile_map[9][c] = T_BDR;
            else if (r == 3) tile_map[9][c] = T_GND;
            else if (r == 4) tile_map[9][c] = 8'h55;
            else tile_map[9][c] = T_SKY;
        end
    endtask

    initial begin
        int w;
        int sel;
        reset = 1'b0;
        move_tick = 1'b0;
        mario_x = -1000;
        mario_y = -1000;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                tile_map[r][c] = (r == 9) ? T_SKY : T_BLK;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        check_state("reset");
        chk("reset_goomba_y", goomba_y, GY);
        reset = 1'b1;
        @(negedge clk);

        // Spawn: the fourth pass wraps the counter, spawns slot 0, and moves it once.
        for (int p = 0; p < 4; p++) begin
            do_pass();
            chk("spawn_active", goomba_active, (p == 3) ? 1 : 0);
        end
        chk("spawn_x0", $signed(goomba_x[31:0]), 599);

        // Reset while a tile request is outstanding.
        hold_ack = 1'b1;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        w = 0;
        while (bus.tile_req !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("midpass_req_seen", bus.tile_req, 1);
        reset = 1'b0;
        #1;
        chk("midpass_async_req", bus.tile_req, 0);
        chk("midpass_async_busy", busy, 0);
        @(negedge clk);
        chk("midpass_req", bus.tile_req, 0);
        chk("midpass_busy", busy, 0);
        chk("midpass_active", goomba_active, 0);
        chk("midpass_lose", lose, 0);
        reset = 1'b1;
        hold_ack = 1'b0;
        model_reset();
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);

        // Open ground: goombas walk to the left screen edge and bounce.
        for (int p = 0; p < 650; p++) begin
            mario_x = $signed($urandom());
            do_pass();
        end

        // Random terrain and far-away Mario positions that would wrap in 32-bit math.
        for (int p = 0; p < 250; p++) begin
            if (p % 10 == 0) random_row9();
            if ($urandom_range(0, 3) == 0) begin
                mario_x = 32'sh8000_0000 + $signed(32'($urandom_range(0, 700)));
                mario_y = 32'($urandom_range(320, 400));
            end else begin
                mario_x = $signed($urandom());
                mario_y = -1000;
            end
            do_pass();
        end

        // Mario from above, then level with a goomba.
        sel = -1;
        for (int s = NS - 1; s >= 0; s--) if (m_act[s]) sel = s;
        if (sel >= 0) begin
            mario_x = m_x[sel] + 10;
            mario_y = 330;
            do_pass();
        end
        sel = -1;
        for (int s = NS - 1; s >= 0; s--) if (m_act[s]) sel = s;
        if (sel >= 0) begin
            mario_x = m_x[sel] + 10;
            mario_y = GY;
            do_pass();
        end
        chk("lose_latched", lose, m_lose);
        mario_x = -1000;
        mario_y = -1000;
        do_pass();
        do_pass();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
